// File: rtl/tpu_fxp_pkg.sv
// Shared fixed-point definitions for the VPU column children (Q8.8 data path).
package tpu_fxp_pkg;

  localparam int unsigned FXP_DATA_W = 16;
  localparam int unsigned FXP_FRAC_W = 8;
  localparam int unsigned FXP_ACC_W  = 24;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } accum_state_t;

  // Callers sign-extend their wide value to 32 bits before calling.
  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return SAT_MAX;
    end else if (v < -32'sd32768) begin
      return SAT_MIN;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/bias_acc_child.sv
// Per-column accumulate-and-bias stage: sums K tile partial sums plus bias,
// saturates to 16 bits and emits one valid pulse per completed element.
module bias_acc_child
  import tpu_fxp_pkg::*;
#(
  parameter int unsigned DATA_W = FXP_DATA_W,
  parameter int unsigned ACC_W  = FXP_ACC_W,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cfg_tiles_in,
  input  logic              psum_valid_in,
  input  logic              psum_first_in,
  input  logic [DATA_W-1:0] psum_in,
  input  logic [DATA_W-1:0] bias_in,
  output logic [DATA_W-1:0] acc_data_out,
  output logic              acc_valid_out,
  output logic              acc_busy_out,
  output logic              acc_err_out
);

  accum_state_t             state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         rem_q, rem_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     err_q, err_d;

  logic signed [ACC_W-1:0]  psum_ext, bias_ext, first_sum, acc_next;
  logic [CNT_W-1:0]         tiles_m1;

  assign psum_ext  = ACC_W'($signed(psum_in));
  assign bias_ext  = ACC_W'($signed(bias_in));
  assign first_sum = psum_ext + bias_ext;
  assign acc_next  = acc_q + psum_ext;
  // A tile count of zero behaves as a single tile.
  assign tiles_m1  = (cfg_tiles_in == '0) ? '0 : cfg_tiles_in - 1'b1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    data_d  = '0;
    valid_d = 1'b0;
    err_d   = err_q;
    if (psum_valid_in) begin
      if (psum_first_in) begin
        // A first beat mid-element abandons the partial sum and restarts.
        if (state_q == ACCUM) begin
          err_d = 1'b1;
        end
        acc_d = first_sum;
        rem_d = tiles_m1;
        if (tiles_m1 == '0) begin
          valid_d = 1'b1;
          data_d  = DATA_W'(sat16(32'(first_sum)));
          state_d = IDLE;
        end else begin
          state_d = ACCUM;
        end
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end else begin
        acc_d = acc_next;
        rem_d = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          valid_d = 1'b1;
          data_d  = DATA_W'(sat16(32'(acc_next)));
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign acc_data_out  = data_q;
  assign acc_valid_out = valid_q;
  assign acc_busy_out  = (state_q == ACCUM);
  assign acc_err_out   = err_q;

endmodule

// File: tb/tb_bias_acc_child.sv
// Directed plus randomized bench for bias_acc_child against an element-level model.
module tb_bias_acc_child;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 24;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] tiles;
  logic          valid, first;
  logic [DW-1:0] psum, bias;
  logic [DW-1:0] data_o;
  logic          v_o, b_o, e_o;

  int checks = 0;
  int failures = 0;

  // Reference model: collects an element's beats and reports its clamped total.
  bit          m_coll, m_err, m_v;
  int          m_sum, m_need, m_got;
  logic [15:0] m_data;

  bias_acc_child #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_tiles_in  (tiles),
    .psum_valid_in (valid),
    .psum_first_in (first),
    .psum_in       (psum),
    .bias_in       (bias),
    .acc_data_out  (data_o),
    .acc_valid_out (v_o),
    .acc_busy_out  (b_o),
    .acc_err_out   (e_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] clamp(input int s);
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic model_reset();
    m_coll = 0; m_err = 0; m_v = 0; m_sum = 0; m_need = 0; m_got = 0; m_data = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, 32'(v_o), 32'(m_v));
    chk({tag, "_data"},  32'(data_o), 32'(m_data));
    chk({tag, "_busy"},  32'(b_o), 32'(m_coll));
    chk({tag, "_err"},   32'(e_o), 32'(m_err));
  endtask

  task automatic beat(input bit v, input bit f, input logic [15:0] p,
                      input logic [15:0] b, input int t);
    int ps, bs;
    @(negedge clk);
    valid = v; first = f; psum = p; bias = b; tiles = t[CW-1:0];
    @(posedge clk);
    #1;
    ps = int'($signed(p));
    bs = int'($signed(b));
    m_v = 0;
    m_data = '0;
    if (v) begin
      if (f) begin
        if (m_coll) m_err = 1;
        m_coll = 1;
        m_sum  = ps + bs;
        m_need = (t == 0) ? 1 : t;
        m_got  = 1;
      end else if (!m_coll) begin
        m_err = 1;
      end else begin
        m_sum += ps;
        m_got++;
      end
      if (m_coll && m_got == m_need) begin
        m_v    = 1;
        m_data = clamp(m_sum);
        m_coll = 0;
      end
    end
    check_outputs("beat");
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) beat(0, 0, 16'($urandom), 16'($urandom), 3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid = 0; first = 0;
    #2 rst = 1;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1; valid = 0; first = 0; psum = '0; bias = '0; tiles = '0;
    #1;
    model_reset();
    check_outputs("por");
    @(negedge clk);
    rst = 0;

    // Single tile.
    beat(1, 1, 16'h0180, 16'h0040, 1);
    chk("t1_data", 32'(data_o), 32'h01C0);
    gap(1);

    // Three tiles with a two-cycle gap.
    beat(1, 1, 16'h0100, 16'h0080, 3);
    beat(1, 0, 16'h0200, 16'h0000, 3);
    gap(2);
    beat(1, 0, 16'hFF00, 16'h0000, 3);
    chk("t3_data", 32'(data_o), 32'h0280);
    gap(1);

    // Saturation both ways.
    beat(1, 1, 16'h7000, 16'h0000, 4);
    for (int i = 0; i < 3; i++) beat(1, 0, 16'h7000, 16'h0000, 4);
    chk("satpos", 32'(data_o), 32'h7FFF);
    beat(1, 1, 16'h9000, 16'h0000, 4);
    for (int i = 0; i < 3; i++) beat(1, 0, 16'h9000, 16'h0000, 4);
    chk("satneg", 32'(data_o), 32'h8000);

    // Reset mid-element.
    beat(1, 1, 16'h0100, 16'h0000, 3);
    beat(1, 0, 16'h0100, 16'h0000, 3);
    do_reset();
    beat(1, 1, 16'h0100, 16'h0000, 1);
    chk("post_rst", 32'(data_o), 32'h0100);

    // Back-to-back two-tile elements.
    beat(1, 1, 16'h0100, 16'h0000, 2);
    beat(1, 0, 16'h0100, 16'h0000, 2);
    chk("b2b_a", 32'(data_o), 32'h0200);
    beat(1, 1, 16'h0040, 16'h0010, 2);
    beat(1, 0, 16'h0040, 16'h0000, 2);
    chk("b2b_b", 32'(data_o), 32'h0090);
    gap(1);

    // Protocol errors: orphan beat, then restart mid-element.
    beat(1, 0, 16'h1234, 16'h0000, 3);
    chk("orphan_err", 32'(e_o), 32'h1);
    beat(1, 1, 16'h0500, 16'h0000, 3);
    beat(1, 0, 16'h0500, 16'h0000, 3);
    beat(1, 1, 16'h0010, 16'h0001, 3);
    beat(1, 0, 16'h0020, 16'h0000, 3);
    beat(1, 0, 16'h0030, 16'h0000, 3);
    chk("restart_data", 32'(data_o), 32'h0061);
    gap(1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      beat($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           16'($urandom), 16'($urandom), int'($urandom_range(0, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
